// File: rtl/ifetch.sv
// ifetch: instruction fetch unit with valid/ready output register, redirect flush,
// halt-on-EBREAK and a sticky misaligned-redirect fault.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit HALT_ON_EBREAK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fault
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_t;
  state_t state, state_d;
  logic [31:0] pc_q, pc_d, instr_d, opc_d;
  logic valid_d, load, ebreak, drained;
  assign load = !out_valid || out_ready;
  assign drained = out_valid && out_ready;
  assign ebreak = HALT_ON_EBREAK && (imem_data == 32'h0010_0073);
  assign imem_addr = pc_q;
  assign halted = state == HALTED;
  assign fault = state == FAULT;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc_q <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc <= '0;
    end else begin
      state <= state_d;
      pc_q <= pc_d;
      out_valid <= valid_d;
      out_instr <= instr_d;
      out_pc <= opc_d;
    end
  end
  // Priority: fault absorbs everything, then redirect, then per-state fetch.
  always_comb begin
    state_d = state;
    pc_d = pc_q;
    valid_d = out_valid;
    instr_d = out_instr;
    opc_d = out_pc;
    if (state == FAULT) begin
      valid_d = 1'b0;
    end else if (redirect_valid) begin
      valid_d = 1'b0;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d = redirect_pc;
        state_d = (state == HALTED) ? RUN : state;
      end else begin
        state_d = FAULT;
      end
    end else if (state == IDLE) begin
      state_d = fetch_en ? RUN : IDLE;
      valid_d = drained ? 1'b0 : out_valid;
    end else if (state == HALTED) begin
      valid_d = drained ? 1'b0 : out_valid;
    end else if (load) begin
      valid_d = fetch_en;
      state_d = !fetch_en ? IDLE : ebreak ? HALTED : RUN;
      if (fetch_en) begin
        instr_d = imem_data;
        opc_d = pc_q;
        pc_d = ebreak ? pc_q : pc_q + 32'd4;
      end
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed scenarios plus randomized run checked against a behavioural model.
module tb_ifetch;
  logic clk = 1'b0, rst_n = 1'b0, fetch_en = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_data, out_instr, out_pc;
  logic out_valid, halted, fault;
  logic [31:0] mem [64];
  int errors = 0, checks = 0;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  ifetch dut (.clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .halted(halted), .fault(fault));

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr[7:2]];

  // Reference model: running/halted/faulted flags and the presented instruction.
  bit m_run, m_halt, m_fault, m_ov;
  logic [31:0] m_pc, m_oi, m_op;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_run <= 0; m_halt <= 0; m_fault <= 0; m_ov <= 0; m_pc <= 0; m_oi <= 0; m_op <= 0;
    end else if (m_fault) begin
      m_ov <= 0;
    end else if (redirect_valid) begin
      m_ov <= 0;
      if (redirect_pc % 4 == 0) begin
        m_pc <= redirect_pc;
        if (m_halt) begin m_halt <= 0; m_run <= 1; end
      end else begin
        m_fault <= 1; m_run <= 0; m_halt <= 0;
      end
    end else if (m_halt || !m_run) begin
      if (out_ready) m_ov <= 0;
      if (!m_halt && fetch_en) m_run <= 1;
    end else if (!m_ov || out_ready) begin
      m_ov <= fetch_en;
      if (!fetch_en) m_run <= 0;
      else begin
        m_oi <= mem[m_pc[7:2]];
        m_op <= m_pc;
        if (mem[m_pc[7:2]] == EBRK) begin m_halt <= 1; m_run <= 0; end
        else m_pc <= m_pc + 4;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i * 32'h0101;
  endtask

  task automatic start();
    rst_n = 0; redirect_valid = 0; fetch_en = 1; out_ready = 1;
    tick();
    rst_n = 1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    fill_mem();
    rst_n = 0; fetch_en = 1; out_ready = 1;
    tick();
    checks++;
    if ({out_valid, halted, fault} !== 3'b000 || imem_addr !== 32'h0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset got v/h/f=%b%b%b addr=%h pc=%h instr=%h required 000 0 0 0",
        out_valid, halted, fault, imem_addr, out_pc, out_instr);
    end
  endtask

  task automatic test_sequential();
    rst_n = 1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL startup_e1 got valid=%b required 0", out_valid); end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== mem[k]) begin
        errors++;
        $display("FAIL seq%0d got v=%b pc=%h instr=%h required 1 %h %h", k, out_valid, out_pc, out_instr, 4 * k, mem[k]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    start();
    tick();
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== mem[1] || imem_addr !== 32'h8) begin
        errors++;
        $display("FAIL stall%0d got v=%b pc=%h instr=%h addr=%h required 1 4 %h 8", k, out_valid, out_pc, out_instr, imem_addr, mem[1]);
      end
    end
    out_ready = 1;
    tick();
    checks++;
    if (out_pc !== 32'h8 || out_instr !== mem[2]) begin
      errors++; $display("FAIL release got pc=%h instr=%h required 8 %h", out_pc, out_instr, mem[2]);
    end
  endtask

  task automatic test_redirect();
    out_ready = 0; redirect_valid = 1; redirect_pc = 32'h40;
    tick();
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL flush got v=%b addr=%h required 0 40", out_valid, imem_addr);
    end
    redirect_valid = 0; out_ready = 1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== mem[16]) begin
      errors++; $display("FAIL target got v=%b pc=%h instr=%h required 1 40 %h", out_valid, out_pc, out_instr, mem[16]);
    end
  endtask

  task automatic test_ebreak();
    mem[3] = EBRK;
    start();
    tick(); tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hC || out_instr !== EBRK || halted !== 1'b1) begin
      errors++; $display("FAIL ebreak got v=%b pc=%h instr=%h halted=%b required 1 c %h 1", out_valid, out_pc, out_instr, halted, EBRK);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 32'hC) begin
        errors++; $display("FAIL halted%0d got v=%b halted=%b addr=%h required 0 1 c", k, out_valid, halted, imem_addr);
      end
    end
    redirect_valid = 1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 0;
    checks++;
    if (halted !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL unhalt got halted=%b v=%b required 0 0", halted, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL restart got v=%b pc=%h required 1 0", out_valid, out_pc);
    end
    fill_mem();
  endtask

  task automatic test_fault();
    start();
    tick();
    redirect_valid = 1; redirect_pc = 32'h42;
    tick();
    checks++;
    if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL fault got f=%b v=%b addr=%h required 1 0 8", fault, out_valid, imem_addr);
    end
    redirect_pc = 32'h40;
    tick();
    tick();
    checks++;
    if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL fault_sticky got f=%b v=%b addr=%h required 1 0 8", fault, out_valid, imem_addr);
    end
    redirect_valid = 0; rst_n = 0;
    tick();
    rst_n = 1;
    checks++;
    if (fault !== 1'b0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL fault_reset got f=%b addr=%h required 0 0", fault, imem_addr);
    end
  endtask

  task automatic test_wrap_reset();
    start();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instr !== mem[63]) begin
      errors++; $display("FAIL wrap_top got v=%b pc=%h required 1 fffffffc", out_valid, out_pc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mem[0]) begin
      errors++; $display("FAIL wrap_zero got v=%b pc=%h required 1 0", out_valid, out_pc);
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL midreset got v=%b addr=%h required 0 0", out_valid, imem_addr);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 9) == 0) ? EBRK : $urandom;
    rst_n = 0; redirect_valid = 0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      rst_n = $urandom_range(0, 99) != 0;
      fetch_en = $urandom_range(0, 7) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 11) == 0;
      redirect_pc = {$urandom_range(0, 63) == 0 ? 24'hFFFFFF : 24'h0, 6'($urandom), 2'b00};
      if ($urandom_range(0, 15) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      tick();
      checks++;
      if (imem_addr !== m_pc || out_valid !== m_ov || out_pc !== m_op || out_instr !== m_oi ||
          halted !== m_halt || fault !== m_fault) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand%0d got addr=%h v=%b pc=%h instr=%h h=%b f=%b required %h %b %h %h %b %b", c,
            imem_addr, out_valid, out_pc, out_instr, halted, fault, m_pc, m_ov, m_op, m_oi, m_halt, m_fault);
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_ebreak();
    test_fault();
    test_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: the requester side of the instruction memory interface. It holds the program counter, drives `imem_addr`, samples the word that `imem` returns combinationally, and presents `{pc, instr}` to decode through a valid/ready output register. It supports branch/jump redirect with flush, halt-on-EBREAK, and a sticky fault on misaligned redirect targets.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value after reset; must be 4-byte aligned.
- `HALT_ON_EBREAK`, default `1`: when 1, fetching `32'h0010_0073` halts the fetch.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `fetch_en`, input, 1: permits fetching while in IDLE/RUN.
- `imem_addr`, output, 32: byte address to `imem`; equals `pc_q`.
- `imem_data`, input, 32: instruction word from `imem`, valid in the same cycle (combinational read).
- `redirect_valid`, input, 1: branch/jump taken this cycle.
- `redirect_pc`, input, 32: redirect target.
- `out_valid`, output, 1: `out_instr`/`out_pc` hold a fetched instruction.
- `out_ready`, input, 1: decode accepts the instruction this cycle.
- `out_instr`, output, 32: fetched instruction word.
- `out_pc`, output, 32: address `out_instr` was fetched from.
- `halted`, output, 1: fetch stopped on EBREAK.
- `fault`, output, 1: sticky misaligned-redirect fault.

## Operation
- States: IDLE, RUN, HALTED, FAULT. Reset state is IDLE.
- Reset values: `pc_q=RESET_PC`, `out_valid=0`, `out_instr=0`, `out_pc=0`, `halted=0`, `fault=0`.
- `load = !out_valid || out_ready`. The output register changes only when `load` is 1, or on a flush.
- Priority in every non-FAULT state is redirect, then EBREAK, then normal fetch.
- Redirect, aligned (`redirect_pc[1:0]==0`):
  - `pc_q<=redirect_pc` and `out_valid<=0`, regardless of `out_ready`. This is the flush.
  - From HALTED, go to RUN and clear `halted`. Otherwise stay in the current state.
- Redirect, misaligned: go to FAULT, `fault<=1`, `out_valid<=0`, `pc_q` unchanged.
- IDLE:
  - If `fetch_en`, go to RUN. No fetch is captured in this cycle.
  - Any pending `out_valid` still drains on `out_ready`.
- RUN with `load` and `fetch_en`:
  - `out_instr<=imem_data`, `out_pc<=pc_q`, `out_valid<=1`, `pc_q<=pc_q+4`. The add wraps modulo 2^32 (`FFFF_FFFC` → `0000_0000`).
- RUN with `load` and `fetch_en` and `HALT_ON_EBREAK` and `imem_data==32'h0010_0073`:
  - Capture and present the EBREAK as above.
  - `pc_q` holds at the EBREAK address; go to HALTED; `halted<=1`.
- RUN with `load` and `!fetch_en`: `out_valid<=0`, go to IDLE.
- RUN with `!load`: stall. All registers hold and `imem_addr` stays stable.
- HALTED:
  - No new fetches.
  - `out_valid` clears once accepted (`out_valid && out_ready`).
  - `fetch_en` is ignored; only a redirect leaves HALTED.
- FAULT:
  - Absorbing until reset; `out_valid=0`.
  - `redirect_valid` and `fetch_en` are ignored.
- Reset mid-operation: `rst_n=0` at an edge overrides every other input and restores all reset values.

## Timing
- `imem_addr` is registered (it is `pc_q`) and stays constant during a stall.
- Fetch latency: 1 cycle. An instruction at `pc_q` in cycle N appears on `out_*` in cycle N+1.
- Throughput: one instruction per cycle while `out_ready=1`.
- Start-up: reset released at edge E0 with `fetch_en=1`:
  - RUN after E1.
  - `out_valid=1`, `out_pc=RESET_PC` after E2.
- Redirect at edge E:
  - `out_valid=0` after E.
  - First target instruction valid after E+1.
  - Penalty is 1 bubble.
- `halted` and `fault` assert in the same cycle as the state change and are registered outputs.

## Test plan
- Sequential fetch: reset, `fetch_en=1`, `out_ready=1`, `imem` preloaded → `out_pc` = 0, 4, 8, 12 on consecutive cycles, each with the matching `out_instr`.
- Backpressure: hold `out_ready=0` for 3 cycles while `out_pc=4`.
  - `out_instr`, `out_pc` and `imem_addr=8` stay stable.
  - After release, `out_pc=8` follows.
- Redirect: `redirect_valid=1`, `redirect_pc=32'h40`, while `out_pc=8` is valid and `out_ready=0`.
  - Next cycle `out_valid=0`.
  - The cycle after, `out_pc=32'h40`.
- EBREAK halt: word at 12 is `32'h0010_0073`.
  - `out_pc=12` is presented and `halted=1`; after acceptance `out_valid=0`.
  - No further fetches, even with `fetch_en=1`.
  - A redirect to `32'h0` restarts fetch with `out_pc=0` and `halted=0`.
- Misaligned redirect to `32'h42`: `fault=1`, `out_valid=0`, `pc_q` unchanged.
  - Later aligned redirects are ignored.
  - `rst_n=0` for one edge restores `pc_q=RESET_PC` and `fault=0`.
- Wrap and mid-run reset:
  - Redirect to `32'hFFFF_FFFC`: `out_pc=FFFF_FFFC`, then `out_pc=0`.
  - Asserting `rst_n=0` mid-stream clears `out_valid` at the next edge.
